operand_stage: RTL
==================

OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Parameter XLEN, default 32, operand/data width.
REQ-002 Parameter CTL_W, default 8, width of opaque decode control bundle carried to EX.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 in_valid/in_ready  in/out  1/1  decode->stage handshake; transfer when both high.
REQ-006 in_rs1, in_rs2, in_rd  in  5 each  source/destination register indices.
REQ-007 in_reg_write, in_mem_read  in  1 each  instr writes rd / instr is a load.
REQ-008 in_imm, in_pc  in  XLEN each; in_ctl  in  CTL_W  carried unmodified.
REQ-009 rf_a1, rf_a2  out  5 each  register-file read addresses; rf_rd1, rf_rd2  in  XLEN  combinational read data.
REQ-010 exm_rd, exm_reg_write, exm_result  in  5/1/XLEN  EX/MEM producer.
REQ-011 mwb_rd, mwb_reg_write, mwb_result  in  5/1/XLEN  MEM/WB producer (same value being written to register file this cycle).
REQ-012 flush  in  1  kill held and incoming instruction.
REQ-013 out_valid/out_ready  out/in  1/1  stage->EX handshake.
REQ-014 out_op1, out_op2, out_imm, out_pc  out  XLEN; out_rd 5; out_reg_write, out_mem_read 1; out_ctl CTL_W.
REQ-015 stall_cnt  out  16  saturating count of hazard-stall cycles.

Function
REQ-016 rf_a1/rf_a2 SHALL equal in_rs1/in_rs2 combinationally.
REQ-017 Operand select (per source, priority order): index 0 -> 0; EX/MEM match (exm_reg_write, exm_rd==rs) -> exm_result; MEM/WB match -> mwb_result; else rf_rd.
REQ-018 Load-use hazard SHALL be: out_valid & out_mem_read & out_rd!=0 & out_rd equals in_rs1 or in_rs2.
REQ-019 States: RUN, HAZ. RUN->HAZ when in_valid & hazard & output register advancing; HAZ->RUN after exactly one cycle.
REQ-020 in_ready = !hazard & (!out_valid | out_ready) & state==RUN-or-hazard-cleared; in HAZ a bubble (out_valid=0) SHALL be loaded.
REQ-021 Output register loads on in_valid&in_ready; operands captured at transfer, held unchanged while out_valid&!out_ready.
REQ-022 out_valid clears when output consumed with no new transfer.
REQ-023 flush SHALL clear out_valid next cycle, force in_ready=0 that cycle, return state to RUN; flush dominates transfer.
REQ-024 stall_cnt SHALL increment each cycle in_valid=1 & in_ready=0 due to hazard; saturate at 16'hFFFF.
REQ-025 Producers upstream of EX SHALL be held by the pipeline while out_ready=0; stage does not re-forward held operands.

Reset
REQ-026 rst=0 at posedge: out_valid=0, state RUN, stall_cnt=0, all data outputs 0; in_ready=1 next cycle.
REQ-027 Reset mid-stall SHALL discard held instruction; no partial transfer.

Configuration
REQ-028 Macro OPERAND_STAGE_FORWARD_EN defined: REQ-017/018 apply (only load-use stalls, one cycle).
REQ-029 Macro undefined: no forwarding, operands from rf_rd only; hazard = any match of in_rs1/in_rs2 (nonzero) with out_rd (out_valid&out_reg_write), exm_rd or mwb_rd with write enable; in_ready held low until clear; HAZ state unused.

Structure
REQ-030 Shared package: XLEN, register-index width 5, state enum {RUN,HAZ}, forward-select enum {FWD_ZERO,FWD_EXM,FWD_MWB,FWD_RF}.
REQ-031 One sub-module operand_fwd_mux (one source operand select), instantiated twice.

Verification
REQ-032 rf x5=10, exm_rd=5 exm_result=99 write, in_rs1=5 -> out_op1=99 (FWD_EN) / in_ready=0 until exm clears (no FWD_EN).
REQ-033 Load rd=7 in output reg, next in_rs2=7 -> in_ready=0 one cycle, bubble out, then out_op2=mwb_result, stall_cnt=1.
REQ-034 exm_rd=mwb_rd=3 both writing, results 1 and 2, in_rs1=3 -> out_op1=1.
REQ-035 in_rs1=0, exm_rd=0 writing 55 -> out_op1=0.
REQ-036 out_ready=0 three cycles with valid held -> outputs stable, in_ready=0; flush -> out_valid=0 next cycle.
REQ-037 rst=0 during HAZ -> out_valid=0, stall_cnt=0, state RUN next cycle.

Source files
------------

// File: rtl/operand_stage_pkg.sv
// operand_stage_pkg: shared widths, FSM states and forwarding selects for the operand stage
package operand_stage_pkg;
    localparam int XLEN = 32;
    localparam int REG_W = 5;
    typedef enum logic {RUN, HAZ} state_e;
    typedef enum logic [1:0] {FWD_ZERO, FWD_EXM, FWD_MWB, FWD_RF} fwd_sel_e;
    function automatic logic reg_hit(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rd, input logic we);
        return we && rs != '0 && rs == rd;
    endfunction
endpackage

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux: priority select of one source operand (x0, EX/MEM, MEM/WB, register file)
module operand_fwd_mux #(
    parameter int XLEN = operand_stage_pkg::XLEN
) (
    input  logic [operand_stage_pkg::REG_W-1:0] rs,
    input  logic [operand_stage_pkg::REG_W-1:0] exm_rd,
    input  logic                                exm_we,
    input  logic [XLEN-1:0]                     exm_result,
    input  logic [operand_stage_pkg::REG_W-1:0] mwb_rd,
    input  logic                                mwb_we,
    input  logic [XLEN-1:0]                     mwb_result,
    input  logic [XLEN-1:0]                     rf_rd,
    output logic [XLEN-1:0]                     op
);
    import operand_stage_pkg::*;
    fwd_sel_e sel;
    // Youngest producer of rs wins; x0 is hard-wired to zero
    always_comb begin
        sel = rs == '0 ? FWD_ZERO : (exm_we && exm_rd == rs) ? FWD_EXM : (mwb_we && mwb_rd == rs) ? FWD_MWB : FWD_RF;
        op = sel == FWD_ZERO ? '0 : sel == FWD_EXM ? exm_result : sel == FWD_MWB ? mwb_result : rf_rd;
    end
endmodule

// File: rtl/operand_stage.sv
// operand_stage: operand fetch/forward and hazard stall between decode and EX; OPERAND_STAGE_FORWARD_EN enables forwarding
module operand_stage #(
    parameter int XLEN = operand_stage_pkg::XLEN,
    parameter int CTL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic             in_reg_write,
    input  logic             in_mem_read,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [CTL_W-1:0] in_ctl,
    output logic [4:0]       rf_a1,
    output logic [4:0]       rf_a2,
    input  logic [XLEN-1:0]  rf_rd1,
    input  logic [XLEN-1:0]  rf_rd2,
    input  logic [4:0]       exm_rd,
    input  logic             exm_reg_write,
    input  logic [XLEN-1:0]  exm_result,
    input  logic [4:0]       mwb_rd,
    input  logic             mwb_reg_write,
    input  logic [XLEN-1:0]  mwb_result,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_op1,
    output logic [XLEN-1:0]  out_op2,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic [CTL_W-1:0] out_ctl,
    output logic [15:0]      stall_cnt
);
    import operand_stage_pkg::*;
`ifdef OPERAND_STAGE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    state_e state_q, state_d;
    logic out_valid_q, out_valid_d, out_reg_write_q, out_reg_write_d, out_mem_read_q, out_mem_read_d;
    logic [XLEN-1:0] out_op1_q, out_op1_d, out_op2_q, out_op2_d, out_imm_q, out_imm_d, out_pc_q, out_pc_d;
    logic [4:0] out_rd_q, out_rd_d;
    logic [CTL_W-1:0] out_ctl_q, out_ctl_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [XLEN-1:0] op1, op2;
    logic hazard, adv, xfer;

    assign rf_a1 = in_rs1;
    assign rf_a2 = in_rs2;

    operand_fwd_mux #(.XLEN(XLEN)) u_fwd1 (
        .rs(in_rs1), .exm_rd(exm_rd), .exm_we(FWD && exm_reg_write), .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_we(FWD && mwb_reg_write), .mwb_result(mwb_result), .rf_rd(rf_rd1), .op(op1)
    );
    operand_fwd_mux #(.XLEN(XLEN)) u_fwd2 (
        .rs(in_rs2), .exm_rd(exm_rd), .exm_we(FWD && exm_reg_write), .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_we(FWD && mwb_reg_write), .mwb_result(mwb_result), .rf_rd(rf_rd2), .op(op2)
    );

    // Stall detection: load-use only when forwarding, otherwise any in-flight writer of a source
    always_comb begin
`ifdef OPERAND_STAGE_FORWARD_EN
        hazard = reg_hit(in_rs1, out_rd_q, out_valid_q && out_mem_read_q)
              || reg_hit(in_rs2, out_rd_q, out_valid_q && out_mem_read_q);
`else
        hazard = reg_hit(in_rs1, out_rd_q, out_valid_q && out_reg_write_q) || reg_hit(in_rs1, exm_rd, exm_reg_write)
              || reg_hit(in_rs1, mwb_rd, mwb_reg_write) || reg_hit(in_rs2, out_rd_q, out_valid_q && out_reg_write_q)
              || reg_hit(in_rs2, exm_rd, exm_reg_write) || reg_hit(in_rs2, mwb_rd, mwb_reg_write);
`endif
        adv = !out_valid_q || out_ready;
        in_ready = !hazard && adv && !flush;
        xfer = in_valid && in_ready;
    end

    // Next state: a stalled load-use drains into a one-cycle bubble (HAZ); flush kills everything
    always_comb begin
        state_d = (FWD && !flush && state_q == RUN && in_valid && hazard && adv) ? HAZ : RUN;
        out_valid_d = flush ? 1'b0 : xfer ? 1'b1 : adv ? 1'b0 : out_valid_q;
        out_op1_d = xfer ? op1 : out_op1_q;
        out_op2_d = xfer ? op2 : out_op2_q;
        out_imm_d = xfer ? in_imm : out_imm_q;
        out_pc_d = xfer ? in_pc : out_pc_q;
        out_rd_d = xfer ? in_rd : out_rd_q;
        out_reg_write_d = xfer ? in_reg_write : out_reg_write_q;
        out_mem_read_d = xfer ? in_mem_read : out_mem_read_q;
        out_ctl_d = xfer ? in_ctl : out_ctl_q;
        stall_cnt_d = (in_valid && hazard && !flush && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    // Output register, FSM state and stall counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            out_valid_q <= 1'b0;
            out_op1_q <= '0;
            out_op2_q <= '0;
            out_imm_q <= '0;
            out_pc_q <= '0;
            out_rd_q <= '0;
            out_reg_write_q <= 1'b0;
            out_mem_read_q <= 1'b0;
            out_ctl_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            out_valid_q <= out_valid_d;
            out_op1_q <= out_op1_d;
            out_op2_q <= out_op2_d;
            out_imm_q <= out_imm_d;
            out_pc_q <= out_pc_d;
            out_rd_q <= out_rd_d;
            out_reg_write_q <= out_reg_write_d;
            out_mem_read_q <= out_mem_read_d;
            out_ctl_q <= out_ctl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op1 = out_op1_q;
    assign out_op2 = out_op2_q;
    assign out_imm = out_imm_q;
    assign out_pc = out_pc_q;
    assign out_rd = out_rd_q;
    assign out_reg_write = out_reg_write_q;
    assign out_mem_read = out_mem_read_q;
    assign out_ctl = out_ctl_q;
    assign stall_cnt = stall_cnt_q;
endmodule
